// File: rtl/dm_write_tracer.sv
// Data-memory write tracer: captures processor stores into a show-ahead FIFO,
// then drains them to a consumer on request and parks in a done state.
module dm_write_tracer #(
    parameter int unsigned N     = 64,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     DM_writeEnable,
    input  logic [N-1:0]             DM_addr,
    input  logic [N-1:0]             DM_writeData,
    input  logic                     dump,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic [N-1:0]             trace_addr,
    output logic [N-1:0]             trace_data,
    output logic                     trace_last,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               drop_count,
    output logic                     done
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FullCount = CW'(DEPTH);

    typedef enum logic [1:0] {StCapture, StDrain, StDone} state_e;

    state_e          state_q, state_d;
    logic [2*N-1:0]  mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      drop_count_q, drop_count_d;
    logic            push, pop, dropped;

    // State register and FIFO bookkeeping
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_q      <= StCapture;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Storage is not reset; validity is tracked solely by count_q
    always_ff @(posedge CLOCK_50) begin
        if (reset && push) begin
            mem_q[wr_ptr_q] <= {DM_addr, DM_writeData};
        end
    end

    always_comb begin
        pop          = trace_valid && trace_ready;
        push         = (state_q == StCapture) && DM_writeEnable && ((count_q != FullCount) || pop);
        dropped      = (state_q == StCapture) && DM_writeEnable && !push;
        wr_ptr_d     = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d      = count_q + CW'(push) - CW'(pop);
        overflow_d   = overflow_q | dropped;
        drop_count_d = drop_count_q;
        if (dropped && drop_count_q != 8'hFF) begin
            drop_count_d = drop_count_q + 8'd1;
        end
    end

    // Next-state logic; DRAIN also exits if it ever finds the FIFO empty
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StCapture: begin
                if (dump) begin
                    state_d = ((count_q != '0) || push) ? StDrain : StDone;
                end
            end
            StDrain: begin
                if (count_d == '0) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StDone;
            default: state_d = StCapture;
        endcase
    end

    always_comb begin
        trace_valid = (count_q != '0) && (state_q != StDone);
        trace_last  = trace_valid && (count_q == CW'(1)) && (state_q == StDrain);
        done        = (state_q == StDone);
        trace_addr  = mem_q[rd_ptr_q][2*N-1:N];
        trace_data  = mem_q[rd_ptr_q][N-1:0];
        count       = count_q;
        overflow    = overflow_q;
        drop_count  = drop_count_q;
    end

endmodule

// File: tb/tb_dm_write_tracer.sv
// Self-checking bench for dm_write_tracer: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_dm_write_tracer;

    localparam int N     = 64;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          we = 1'b0;
    logic [N-1:0]  addr = '0;
    logic [N-1:0]  wdata = '0;
    logic          dump = 1'b0;
    logic          ready = 1'b0;
    logic          trace_valid, trace_last, overflow, done;
    logic [N-1:0]  trace_addr, trace_data;
    logic [3:0]    count;
    logic [7:0]    drop_count;

    int checks = 0;
    int errors = 0;

    // Reference model: an ordered queue of captured stores plus phase flags
    logic [2*N-1:0] mq[$];
    int             m_state;   // 0 capturing, 1 draining, 2 finished
    bit             m_ovf;
    int             m_drop;

    dm_write_tracer #(.N(N), .DEPTH(DEPTH)) dut (
        .CLOCK_50      (clk),
        .reset         (rst_n),
        .DM_writeEnable(we),
        .DM_addr       (addr),
        .DM_writeData  (wdata),
        .dump          (dump),
        .trace_valid   (trace_valid),
        .trace_ready   (ready),
        .trace_addr    (trace_addr),
        .trace_data    (trace_data),
        .trace_last    (trace_last),
        .count         (count),
        .overflow      (overflow),
        .drop_count    (drop_count),
        .done          (done)
    );

    always #5 clk = ~clk;

    // Expected {valid, last, count, overflow, drop_count, done}
    function automatic logic [15:0] model_flags();
        logic v;
        v = (mq.size() != 0) && (m_state != 2);
        return {v, v && mq.size() == 1 && m_state == 1, 4'(mq.size()), m_ovf, 8'(m_drop),
                m_state == 2};
    endfunction

    task automatic tick();
        bit v, pop, push;
        int sz;
        sz  = mq.size();
        v   = (sz != 0) && (m_state != 2);
        pop = v && ready;
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            m_state = 0;
            m_ovf   = 0;
            m_drop  = 0;
        end else begin
            push = (m_state == 0) && we && (sz < DEPTH || pop);
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back({addr, wdata});
            if (m_state == 0 && we && !push) begin
                m_ovf = 1;
                if (m_drop < 255) m_drop++;
            end
            if (m_state == 0 && dump) m_state = (sz != 0 || push) ? 1 : 2;
            else if (m_state == 1 && mq.size() == 0) m_state = 2;
        end
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; we = 1'b0; dump = 1'b0; ready = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; we = 1'b1; ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            addr = 64'(i); wdata = 64'(i); tick();
        end
        rst_n = 1'b0; we = 1'b1; dump = 1'b1; ready = 1'b1;
        tick();
        checks++;
        if ({trace_valid, trace_last, count, overflow, drop_count, done} !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h",
                     {trace_valid, trace_last, count, overflow, drop_count, done}, 16'h0);
        end
        rst_n = 1'b1; we = 1'b0; dump = 1'b0; ready = 1'b0;
    endtask

    task automatic test_basic();
        apply_reset();
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            we = 1'b1; addr = 64'(i * 8); wdata = 64'(i + 1);
            tick();
            checks++;
            if (!(trace_valid === 1'b1 && trace_addr === 64'(i * 8) && trace_data === 64'(i + 1)))
            begin
                errors++;
                $display("FAIL basic_head%0d: got v=%b a=%h d=%h expected v=1 a=%h d=%h",
                         i, trace_valid, trace_addr, trace_data, i * 8, i + 1);
            end
        end
        we = 1'b0;
        tick();
        checks++;
        if (count !== 4'd0 || trace_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_empty: got count=%0d v=%b expected 0 0", count, trace_valid);
        end
    endtask

    task automatic test_overflow();
        logic [N-1:0] ed[10];
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            ed[i] = {$urandom, $urandom};
            we = 1'b1; addr = 64'(i * 8); wdata = ed[i];
            tick();
        end
        we = 1'b0;
        checks++;
        if (count !== 4'd8 || overflow !== 1'b1 || drop_count !== 8'd2) begin
            errors++;
            $display("FAIL overflow_state: got count=%0d ovf=%b drops=%0d expected 8 1 2",
                     count, overflow, drop_count);
        end
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (trace_valid !== 1'b1 || trace_addr !== 64'(i * 8) || trace_data !== ed[i]) begin
                errors++;
                $display("FAIL overflow_drain%0d: got v=%b a=%h d=%h expected 1 %h %h",
                         i, trace_valid, trace_addr, trace_data, i * 8, ed[i]);
            end
            tick();
        end
        checks++;
        if (count !== 4'd0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_after: got count=%0d ovf=%b expected 0 1", count, overflow);
        end
    endtask

    task automatic test_full_push_pop();
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            we = 1'b1; addr = 64'(i); wdata = {$urandom, $urandom};
            tick();
        end
        ready = 1'b1; addr = 64'h99; wdata = 64'hABCD;
        tick();
        we = 1'b0;
        checks++;
        if (count !== 4'd8 || overflow !== 1'b0 || drop_count !== 8'd0) begin
            errors++;
            $display("FAIL full_pushpop: got count=%0d ovf=%b drops=%0d expected 8 0 0",
                     count, overflow, drop_count);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (trace_valid !== 1'b1 || {trace_addr, trace_data} !== mq[0]) begin
                errors++;
                $display("FAIL full_drain%0d: got %h_%h expected %h",
                         i, trace_addr, trace_data, mq[0]);
            end
            if (i == 7) begin
                checks++;
                if (trace_addr !== 64'h99 || trace_data !== 64'hABCD) begin
                    errors++;
                    $display("FAIL full_tail: got %h %h expected 99 abcd", trace_addr, trace_data);
                end
            end
            tick();
        end
    endtask

    task automatic test_drain();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            we = 1'b1; addr = 64'(i); wdata = 64'(100 + i);
            tick();
        end
        we = 1'b0; dump = 1'b1;
        tick();
        dump = 1'b0; we = 1'b1; addr = 64'hDEAD; ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (count !== 4'(5 - i) || trace_last !== (i == 4) || trace_data !== 64'(100 + i)
                || done !== 1'b0) begin
                errors++;
                $display("FAIL drain_pop%0d: got count=%0d last=%b d=%h done=%b expected %0d %b %h 0",
                         i, count, trace_last, trace_data, done, 5 - i, i == 4, 100 + i);
            end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            dump = i[0];
            checks++;
            if (done !== 1'b1 || trace_valid !== 1'b0 || count !== 4'd0 || drop_count !== 8'd0)
            begin
                errors++;
                $display("FAIL drain_done%0d: got done=%b v=%b count=%0d drops=%0d expected 1 0 0 0",
                         i, done, trace_valid, count, drop_count);
            end
            tick();
        end
        dump = 1'b0; we = 1'b0;
    endtask

    task automatic test_empty_dump();
        apply_reset();
        dump = 1'b1;
        tick();
        dump = 1'b0;
        checks++;
        if (done !== 1'b1 || trace_valid !== 1'b0) begin
            errors++;
            $display("FAIL empty_dump: got done=%b v=%b expected 1 0", done, trace_valid);
        end
    endtask

    task automatic test_reset_mid_drain();
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            we = 1'b1; addr = 64'(i); wdata = 64'(i);
            tick();
        end
        we = 1'b0; dump = 1'b1; ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        dump = 1'b0; ready = 1'b0;
        checks++;
        if (count !== 4'd4 || done !== 1'b0) begin
            errors++;
            $display("FAIL middrain_pre: got count=%0d done=%b expected 4 0", count, done);
        end
        rst_n = 1'b0; ready = 1'b1;
        tick();
        rst_n = 1'b1;
        checks++;
        if (count !== 4'd0 || done !== 1'b0 || overflow !== 1'b0 || trace_valid !== 1'b0) begin
            errors++;
            $display("FAIL middrain_reset: got count=%0d done=%b ovf=%b v=%b expected 0 0 0 0",
                     count, done, overflow, trace_valid);
        end
        ready = 1'b0; we = 1'b1; addr = 64'h40; wdata = 64'h77;
        tick();
        we = 1'b0;
        checks++;
        if (trace_valid !== 1'b1 || trace_addr !== 64'h40 || trace_data !== 64'h77 ||
            count !== 4'd1) begin
            errors++;
            $display("FAIL middrain_capture: got v=%b a=%h d=%h count=%0d expected 1 40 77 1",
                     trace_valid, trace_addr, trace_data, count);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            we    = ($urandom_range(0, 9) < 7);
            ready = ($urandom_range(0, 9) < 4);
            dump  = ($urandom_range(0, 59) == 0);
            addr  = {$urandom, $urandom};
            wdata = {$urandom, $urandom};
            tick();
            checks++;
            if ({trace_valid, trace_last, count, overflow, drop_count, done} !== model_flags()) begin
                errors++;
                $display("FAIL random_flags@%0d: got %h expected %h", i,
                         {trace_valid, trace_last, count, overflow, drop_count, done},
                         model_flags());
            end
            if (mq.size() != 0 && m_state != 2) begin
                checks++;
                if ({trace_addr, trace_data} !== mq[0]) begin
                    errors++;
                    $display("FAIL random_head@%0d: got %h_%h expected %h", i,
                             trace_addr, trace_data, mq[0]);
                end
            end
        end
        rst_n = 1'b1; we = 1'b0; dump = 1'b0;
    endtask

    initial begin
        mq.delete();
        m_state = 0; m_ovf = 0; m_drop = 0;
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_drain();
        test_empty_dump();
        test_reset_mid_drain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_write_tracer.md
DM_WRITE_TRACER -- requirements
Module: dm_write_tracer

Interface
REQ-001 Parameter N, default 64, width of data-memory address and data.
REQ-002 Parameter DEPTH, default 8, trace FIFO entries; power of two, 2..256.
REQ-003 CLOCK_50  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled only on rising edge of CLOCK_50.
REQ-005 DM_writeEnable  input  1  processor data-memory write strobe, one write per high cycle.
REQ-006 DM_addr  input  N  data-memory write address.
REQ-007 DM_writeData  input  N  data-memory write data.
REQ-008 dump  input  1  level request to stop capture and drain the trace.
REQ-009 trace_valid  output  1  head entry available.
REQ-010 trace_ready  input  1  consumer accepts head entry.
REQ-011 trace_addr  output  N  head entry address.
REQ-012 trace_data  output  N  head entry data.
REQ-013 trace_last  output  1  head entry is final entry of drain.
REQ-014 count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-015 overflow  output  1  sticky: at least one write dropped.
REQ-016 drop_count  output  8  dropped writes, saturating.
REQ-017 done  output  1  drain complete.

Function
REQ-018 States: CAPTURE, DRAIN, DONE; reset state CAPTURE.
REQ-019 CAPTURE: push {DM_addr, DM_writeData} when DM_writeEnable=1 and (count<DEPTH or pop in same cycle).
REQ-020 CAPTURE, write while full with no pop: entry dropped, overflow<=1, drop_count+1, saturating at 255.
REQ-021 Pop occurs when trace_valid=1 and trace_ready=1, in any state.
REQ-022 FIFO show-ahead: trace_valid=(count!=0); trace_addr/trace_data reflect head entry, stable while trace_valid=1 and trace_ready=0.
REQ-023 Latency: write sampled at edge k visible on trace outputs after edge k (1 cycle) when FIFO was empty.
REQ-024 Simultaneous push and pop: count unchanged; ordering preserved, strict FIFO.
REQ-025 Pointers wrap modulo DEPTH; count range 0..DEPTH.
REQ-026 CAPTURE -> DRAIN on edge where dump=1 and count or push nonzero; CAPTURE -> DONE directly if dump=1, count=0, no push that cycle.
REQ-027 Write coincident with dump-transition edge is captured (subject to REQ-020).
REQ-028 DRAIN/DONE: DM_writeEnable ignored; no push, drop_count unchanged.
REQ-029 trace_last = trace_valid and count=1 and state=DRAIN; 0 in CAPTURE.
REQ-030 DRAIN -> DONE on edge where pop leaves count=0.
REQ-031 DONE: done=1, trace_valid=0; held until reset; dump ignored.
REQ-032 dump deassertion during DRAIN has no effect.

Reset
REQ-033 reset=0 at edge: state=CAPTURE, pointers and count=0, overflow=0, drop_count=0, done=0, trace_valid=0, trace_last=0; FIFO contents need not clear.
REQ-034 Reset has priority over push, pop and dump in the same cycle; reset mid-DRAIN discards all entries.

Verification
REQ-035 Three writes (addr 0x0,0x8,0x10; data 1,2,3), trace_ready=1 -> three pops in order, trace_valid one cycle after each write, count returns 0.
REQ-036 DEPTH=8, trace_ready=0, ten writes -> count=8, overflow=1, drop_count=2; then ready=1 -> first eight entries drained in order.
REQ-037 Full FIFO, write and pop same cycle -> count stays 8, no drop, new entry at tail.
REQ-038 Five entries queued, dump=1 -> state DRAIN, writes ignored, trace_last only on fifth pop, done=1 next edge, holds.
REQ-039 Empty FIFO, dump=1 -> done=1 after one edge, trace_valid=0.
REQ-040 reset=0 mid-DRAIN with 4 entries -> count=0, done=0, overflow=0; new writes captured.
